bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared 16-bit tiny16 bus.
- Decides which of N requesters (controller, memory loader, debug port, ...) may assert its out_en onto the bus in a given cycle.
- Produces one-hot grants, and inserts a one-cycle dead turnaround on every ownership change so no two drivers ever overlap.
- Sits between the requesting units and their bus output-enable gating in the top level.

---
 rtl/bus_arbiter_if.sv | 22 ++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbitration handshake bundle: requesters drive req/lock, the arbiter
// returns a one-hot grant plus owner index, busy and timeout status.
interface bus_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic         timeout;

  modport master (
    output req, lock,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  req, lock,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin tiny16 bus arbiter with a one-cycle dead turnaround between owners.
// Define BUS_ARB_TIMEOUT_EN to enable MAX_HOLD tenure limiting with lock override.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t         state;
  logic [N-1:0]   grant_q;
  logic [2:0]     grant_id_q;
  logic [2:0]     ptr;
  logic           busy_q;
  logic           timeout_q;

  logic           sel_valid;
  logic [2:0]     sel_id;
  logic [3:0]     sel_sum;
  logic [2*N-1:0] req_rot;
  logic [N-1:0]   sel_onehot;
  logic           owner_req;
  logic [2:0]     ptr_after_owner;

  // Rotating the doubled request vector by ptr turns the round-robin scan
  // into a plain lowest-index search over req_rot[N-1:0].
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel_valid = 1'b0;
    sel_sum   = '0;
    req_rot   = {bus.req, bus.req} >> ptr;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sel_valid = 1'b1;
        sel_sum   = {1'b0, ptr} + 4'(i);
      end
    end
    sel_id = (sel_sum >= 4'(N)) ? 3'(sel_sum - 4'(N)) : sel_sum[2:0];
  end

  assign sel_onehot      = {{(N-1){1'b0}}, 1'b1} << sel_id;
  assign owner_req       = |(bus.req & grant_q);
  assign ptr_after_owner = (grant_id_q == 3'(N - 1)) ? 3'd0 : grant_id_q + 3'd1;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt;
  logic          revoke;

  // A locked owner parks the counter at HOLD_LAST, so revoke fires on the
  // first edge where the lock is gone and someone else is waiting.
  assign revoke = (hold_cnt == HOLD_LAST) && (|(bus.req & ~grant_q))
                  && !(|(bus.lock & grant_q));

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (^bus.lock) ^ (MAX_HOLD > 0);
`endif

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset checked first inside the clocked block; all state uses <= only.
    if (!rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr        <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        IDLE, TURN: begin
          if (sel_valid) begin
            state      <= GRANT;
            grant_q    <= sel_onehot;
            grant_id_q <= sel_id;
            busy_q     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state   <= TURN;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr     <= ptr_after_owner;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (revoke) begin
            state     <= TURN;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr       <= ptr_after_owner;
            timeout_q <= 1'b1;
          end
`endif
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table for rotation/reset/handover
// plus hand sequences for tenure limiting (expectations follow BUS_ARB_TIMEOUT_EN).
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.N(N)) bus ();

  bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [2:0]   id;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] g, input logic b,
                            input logic t, input logic [2:0] id, input bit chk_id);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
    if (chk_id) check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(id));
    check({tag, ".onehot"}, 32'($countones(bus.grant) <= 1), 32'd1);
    check({tag, ".busy_eq_or"}, 32'(bus.busy), 32'(|bus.grant));
  endtask

  initial begin
    // Reset held with everyone requesting, then fair rotation with 3-cycle tenures.
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 3'd0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0001, 3'd0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0001, 3'd0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0001, 3'd0});
    vecs.push_back('{1'b1, 4'b1110, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0010, 3'd1});
    vecs.push_back('{1'b1, 4'b1111, 4'b0010, 3'd1});
    vecs.push_back('{1'b1, 4'b1111, 4'b0010, 3'd1});
    vecs.push_back('{1'b1, 4'b1101, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0100, 3'd2});
    vecs.push_back('{1'b1, 4'b1111, 4'b0100, 3'd2});
    vecs.push_back('{1'b1, 4'b1111, 4'b0100, 3'd2});
    vecs.push_back('{1'b1, 4'b1011, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b1111, 4'b1000, 3'd3});
    vecs.push_back('{1'b1, 4'b1111, 4'b1000, 3'd3});
    vecs.push_back('{1'b1, 4'b1111, 4'b1000, 3'd3});
    vecs.push_back('{1'b1, 4'b0111, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0001, 3'd0});
    vecs.push_back('{1'b1, 4'b1110, 4'b0000, 3'd0});
    // TURN with nobody waiting falls back to IDLE.
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    // Lone requester 2 from IDLE, then release.
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 3'd2});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    // ptr=3: scan wraps to 0; single requester re-granted after one TURN.
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, 3'd0});
    // Owner drops in its first grant cycle.
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    // ptr=1 with req 1001: 3 wins; pending 0 does not shorten tenure.
    vecs.push_back('{1'b1, 4'b1001, 4'b1000, 3'd3});
    vecs.push_back('{1'b1, 4'b1001, 4'b1000, 3'd3});
    vecs.push_back('{1'b1, 4'b0001, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    // Owner 1 holding with req 0011, reset mid-tenure; ptr returns to 0.
    vecs.push_back('{1'b1, 4'b0011, 4'b0010, 3'd1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0010, 3'd1});
    vecs.push_back('{1'b0, 4'b0011, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0011, 4'b0001, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 3'd0});

    rst      = 1'b0;
    bus.req  = '0;
    bus.lock = '0;

    for (int v = 0; v < vecs.size(); v++) begin
      rst     = vecs[v].rst;
      bus.req = vecs[v].req;
      tick();
      check_outs($sformatf("vec%0d", v), vecs[v].grant, |vecs[v].grant, 1'b0,
                 vecs[v].id, (vecs[v].grant != 0) || !vecs[v].rst);
    end

    // Owner 0 never releases while requester 3 waits.
    bus.req = 4'b0001;
    tick();
    check_outs("rv_enter", 4'b0001, 1'b1, 1'b0, 3'd0, 1'b1);
    bus.req = 4'b1001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_outs($sformatf("rv_hold%0d", c), 4'b0001, 1'b1, 1'b0, 3'd0, 1'b1);
    end
    tick();
    check_outs("rv_revoke", TO_EN ? 4'b0000 : 4'b0001, !TO_EN, TO_EN, 3'd0, !TO_EN);
    tick();
    check_outs("rv_next", TO_EN ? 4'b1000 : 4'b0001, 1'b1, 1'b0, TO_EN ? 3'd3 : 3'd0, 1'b1);
    bus.req = 4'b0000;
    tick();
    check_outs("rv_release", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    check_outs("rv_idle", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);

    // Same contention with lock[0] set: no revoke until lock drops.
    bus.req  = 4'b0001;
    bus.lock = 4'b0001;
    tick();
    check_outs("lk_enter", 4'b0001, 1'b1, 1'b0, 3'd0, 1'b1);
    bus.req = 4'b1001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check_outs($sformatf("lk_hold%0d", c), 4'b0001, 1'b1, 1'b0, 3'd0, 1'b1);
    end
    bus.lock = 4'b0000;
    tick();
    check_outs("lk_revoke", TO_EN ? 4'b0000 : 4'b0001, !TO_EN, TO_EN, 3'd0, !TO_EN);
    tick();
    check_outs("lk_next", TO_EN ? 4'b1000 : 4'b0001, 1'b1, 1'b0, TO_EN ? 3'd3 : 3'd0, 1'b1);
    bus.req = 4'b0000;
    tick();
    check_outs("lk_release", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    check_outs("lk_idle", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
